vx_hw_itr_ctrl: RTL and testbench

//  Per-core hardware interrupt controller; consumes CSR read/write traffic the SFU CSR unit sends on its

---
 rtl/vx_hw_itr_ctrl_pkg.sv | 28 ++
 rtl/vx_hw_itr_edge_sync.sv | 35 +++
 rtl/vx_hw_itr_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_vx_hw_itr_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_hw_itr_ctrl_pkg.sv
// rtl/vx_hw_itr_ctrl_pkg.sv - shared types and CSR offsets for the hardware interrupt controller
//
// Purpose: controller FSM state type, CSR window base and per-register offsets.
// Ports:   none (package).
// Macros:  HW_ITR_TIMER_EN enables the timer registers at offsets 5..8.

package vx_hw_itr_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_EOI = 2'd2
   } hw_itr_state_e;

   localparam int VX_HW_ITR_CTRL_BEGIN = 'h7C0;
   localparam int VX_HW_ITR_CTRL_END   = 'h7C8;

   localparam logic [3:0] HW_ITR_MIE         = 4'd0;
   localparam logic [3:0] HW_ITR_MIP         = 4'd1;
   localparam logic [3:0] HW_ITR_MCAUSE      = 4'd2;
   localparam logic [3:0] HW_ITR_EOI         = 4'd3;
   localparam logic [3:0] HW_ITR_GIE         = 4'd4;
   localparam logic [3:0] HW_ITR_MTIMECMP_LO = 4'd5;
   localparam logic [3:0] HW_ITR_MTIMECMP_HI = 4'd6;
   localparam logic [3:0] HW_ITR_MTIME_LO    = 4'd7;
   localparam logic [3:0] HW_ITR_MTIME_HI    = 4'd8;

endpackage

// File: rtl/vx_hw_itr_edge_sync.sv
// rtl/vx_hw_itr_edge_sync.sv - two-flop synchroniser with rising-edge pulse output
//
// Purpose: brings asynchronous level IRQ lines into the clock domain and emits
//          a one-cycle pulse per line on each low-to-high transition.
// Ports:   clk   in  core clock
//          reset in  asynchronous active-low reset
//          din   in  WIDTH raw asynchronous lines
//          rise  out WIDTH one-cycle rising-edge pulses

module vx_hw_itr_edge_sync #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] sync_q1, sync_q2, prev_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
         prev_q  <= '0;
      end else begin
         sync_q1 <= din;
         sync_q2 <= sync_q1;
         prev_q  <= sync_q2;
      end
   end

   assign rise = sync_q2 & ~prev_q;

endmodule

// File: rtl/vx_hw_itr_ctrl.sv
// rtl/vx_hw_itr_ctrl.sv - per-core hardware interrupt controller on the SFU CSR bus
//
// Purpose: per-warp MIE/MIP/MCAUSE state, global enable, round-robin warp
//          arbitration and a valid/ready request to the warp scheduler that is
//          retired by an EOI write from the served warp.
// Ports:   clk, reset (async active-low)
//          irq_in                                   external level IRQ lines
//          csr_rd_en/csr_rd_wid/csr_rd_addr/csr_rd_data  combinational CSR read
//          csr_wr_en/csr_wr_wid/csr_wr_addr/csr_wr_data  CSR write (lane 0 used)
//          itr_valid/itr_wid/itr_cause/itr_ready    request to scheduler
//          itr_busy                                 request outstanding
// Macros:  HW_ITR_TIMER_EN adds the 64-bit MTIME/MTIMECMP timer driving line 0.

module vx_hw_itr_ctrl
   import vx_hw_itr_ctrl_pkg::*;
#(
   parameter int  WARP_CNT   = 4,
   parameter int  THREAD_CNT = 4,
   parameter int  IRQ_LINES  = 8,
   parameter int  ADDR_BITS  = 12,
   localparam int WID_W      = (WARP_CNT > 1) ? $clog2(WARP_CNT) : 1,
   localparam int LID_W      = (IRQ_LINES > 1) ? $clog2(IRQ_LINES) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [IRQ_LINES-1:0]    irq_in,
   input  logic                    csr_rd_en,
   input  logic [WID_W-1:0]        csr_rd_wid,
   input  logic [ADDR_BITS-1:0]    csr_rd_addr,
   output logic [THREAD_CNT*32-1:0] csr_rd_data,
   input  logic                    csr_wr_en,
   input  logic [WID_W-1:0]        csr_wr_wid,
   input  logic [ADDR_BITS-1:0]    csr_wr_addr,
   input  logic [THREAD_CNT*32-1:0] csr_wr_data,
   output logic                    itr_valid,
   output logic [WID_W-1:0]        itr_wid,
   output logic [LID_W-1:0]        itr_cause,
   input  logic                    itr_ready,
   output logic                    itr_busy
);

   logic [IRQ_LINES-1:0] mie [WARP_CNT];
   logic [IRQ_LINES-1:0] mip [WARP_CNT];
   logic                 mc_valid [WARP_CNT];
   logic [LID_W-1:0]     mc_lid [WARP_CNT];
   logic                 gie;
   logic [WID_W-1:0]     last_wid, cur_wid;
   logic [LID_W-1:0]     cur_cause;
   hw_itr_state_e        state, state_n;

   logic [IRQ_LINES-1:0] ext_rise, irq_edge, lid_onehot;
   logic [ADDR_BITS-1:0] rd_off, wr_off;
   logic                 rd_hit, wr_hit;
   logic [31:0]          wr_lane0, rd_val;
   logic                 wr_mie, wr_mip, wr_gie, hs, eoi;
   logic                 arb_found;
   logic [WID_W-1:0]     arb_wid, aw;
   logic [LID_W-1:0]     arb_lid;
   logic                 unused_wr_bits;

   vx_hw_itr_edge_sync #(.WIDTH(IRQ_LINES)) u_edge_sync (
      .clk   (clk),
      .reset (reset),
      .din   (irq_in),
      .rise  (ext_rise)
   );

   assign rd_off   = csr_rd_addr - ADDR_BITS'(VX_HW_ITR_CTRL_BEGIN);
   assign wr_off   = csr_wr_addr - ADDR_BITS'(VX_HW_ITR_CTRL_BEGIN);
   assign rd_hit   = (rd_off[ADDR_BITS-1:4] == '0);
   assign wr_hit   = csr_wr_en && (wr_off[ADDR_BITS-1:4] == '0);
   assign wr_lane0 = csr_wr_data[31:0];
   assign unused_wr_bits = &{1'b0, csr_wr_data};

   assign wr_mie = wr_hit && (wr_off[3:0] == HW_ITR_MIE);
   assign wr_mip = wr_hit && (wr_off[3:0] == HW_ITR_MIP);
   assign wr_gie = wr_hit && (wr_off[3:0] == HW_ITR_GIE);
   assign hs     = (state == REQ) && itr_ready;
   assign eoi    = wr_hit && (wr_off[3:0] == HW_ITR_EOI) &&
                   (state == WAIT_EOI) && (csr_wr_wid == cur_wid);
   assign lid_onehot = IRQ_LINES'(1) << cur_cause;

`ifdef HW_ITR_TIMER_EN
   logic [63:0] mtime, mtimecmp;
   logic        tmr_hit, tmr_hit_q;

   assign tmr_hit = (mtime >= mtimecmp);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mtime     <= '0;
         mtimecmp  <= '1;
         tmr_hit_q <= 1'b0;
      end else begin
         mtime     <= mtime + 64'd1;
         tmr_hit_q <= tmr_hit;
         if (wr_hit && wr_off[3:0] == HW_ITR_MTIMECMP_LO) mtimecmp[31:0]  <= wr_lane0;
         if (wr_hit && wr_off[3:0] == HW_ITR_MTIMECMP_HI) mtimecmp[63:32] <= wr_lane0;
      end
   end

   // Timer crossing its compare value behaves like a fresh edge on line 0.
   assign irq_edge = ext_rise | IRQ_LINES'(tmr_hit & ~tmr_hit_q);
`else
   assign irq_edge = ext_rise;
`endif

   // Round-robin over warps starting after the last one served; the winning
   // warp's lowest pending-and-enabled line becomes the cause.
   always_comb begin
      arb_found = 1'b0;
      arb_wid   = '0;
      arb_lid   = '0;
      aw        = '0;
      for (int i = 1; i <= WARP_CNT; i++) begin
         aw = WID_W'((int'(last_wid) + i) % WARP_CNT);
         if (!arb_found && gie && |(mip[aw] & mie[aw])) begin
            arb_found = 1'b1;
            arb_wid   = aw;
            for (int j = IRQ_LINES - 1; j >= 0; j--) begin
               if (mip[aw][j] && mie[aw][j]) arb_lid = LID_W'(j);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:     if (arb_found) state_n = REQ;
         REQ:      if (itr_ready) state_n = WAIT_EOI;
         WAIT_EOI: if (eoi)       state_n = IDLE;
         default:                 state_n = IDLE;
      endcase
   end

   always_comb begin
      itr_valid = (state == REQ);
      itr_busy  = (state != IDLE);
      itr_wid   = cur_wid;
      itr_cause = cur_cause;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int w = 0; w < WARP_CNT; w++) begin
            mie[w]      <= '0;
            mip[w]      <= '0;
            mc_valid[w] <= 1'b0;
            mc_lid[w]   <= '0;
         end
         gie       <= 1'b0;
         last_wid  <= WID_W'(WARP_CNT - 1);
         cur_wid   <= '0;
         cur_cause <= '0;
      end else begin
         for (int w = 0; w < WARP_CNT; w++) begin
            if (wr_mie && csr_wr_wid == WID_W'(w)) mie[w] <= wr_lane0[IRQ_LINES-1:0];
            // New edges are ORed in last so they win over W1C and grant clears.
            mip[w] <= (mip[w]
                       & ~((wr_mip && csr_wr_wid == WID_W'(w)) ? wr_lane0[IRQ_LINES-1:0] : '0)
                       & ~((hs && cur_wid == WID_W'(w)) ? lid_onehot : '0))
                      | irq_edge;
            if (hs && cur_wid == WID_W'(w)) begin
               mc_valid[w] <= 1'b1;
               mc_lid[w]   <= cur_cause;
            end else if (eoi && cur_wid == WID_W'(w)) begin
               mc_valid[w] <= 1'b0;
               mc_lid[w]   <= '0;
            end
         end
         if (wr_gie) gie <= wr_lane0[0];
         if (state == IDLE && arb_found) begin
            cur_wid   <= arb_wid;
            cur_cause <= arb_lid;
         end
         if (hs) last_wid <= cur_wid;
      end
   end

   always_comb begin
      rd_val = '0;
      if (csr_rd_en && rd_hit) begin
         case (rd_off[3:0])
            HW_ITR_MIE:    rd_val = 32'(mie[csr_rd_wid]);
            HW_ITR_MIP:    rd_val = 32'(mip[csr_rd_wid]);
            HW_ITR_MCAUSE: rd_val = {mc_valid[csr_rd_wid], (31 - LID_W)'(0), mc_lid[csr_rd_wid]};
            HW_ITR_GIE:    rd_val = {31'd0, gie};
`ifdef HW_ITR_TIMER_EN
            HW_ITR_MTIMECMP_LO: rd_val = mtimecmp[31:0];
            HW_ITR_MTIMECMP_HI: rd_val = mtimecmp[63:32];
            HW_ITR_MTIME_LO:    rd_val = mtime[31:0];
            HW_ITR_MTIME_HI:    rd_val = mtime[63:32];
`endif
            default:       rd_val = '0;
         endcase
      end
      csr_rd_data = {THREAD_CNT{rd_val}};
   end

endmodule

// File: tb/tb_vx_hw_itr_ctrl.sv
// tb/tb_vx_hw_itr_ctrl.sv - self-checking bench for vx_hw_itr_ctrl

module tb_vx_hw_itr_ctrl;
   import vx_hw_itr_ctrl_pkg::*;

   localparam int WC = 4;
   localparam int TC = 4;
   localparam int NL = 8;
   localparam int AB = 12;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [NL-1:0]   irq_in = '0;
   logic            csr_rd_en = 1'b0;
   logic [1:0]      csr_rd_wid = '0;
   logic [AB-1:0]   csr_rd_addr = '0;
   logic [TC*32-1:0] csr_rd_data;
   logic            csr_wr_en = 1'b0;
   logic [1:0]      csr_wr_wid = '0;
   logic [AB-1:0]   csr_wr_addr = '0;
   logic [TC*32-1:0] csr_wr_data = '0;
   logic            itr_valid;
   logic [1:0]      itr_wid;
   logic [2:0]      itr_cause;
   logic            itr_ready = 1'b0;
   logic            itr_busy;

   vx_hw_itr_ctrl #(.WARP_CNT(WC), .THREAD_CNT(TC), .IRQ_LINES(NL), .ADDR_BITS(AB)) dut (
      .clk         (clk),
      .reset       (reset),
      .irq_in      (irq_in),
      .csr_rd_en   (csr_rd_en),
      .csr_rd_wid  (csr_rd_wid),
      .csr_rd_addr (csr_rd_addr),
      .csr_rd_data (csr_rd_data),
      .csr_wr_en   (csr_wr_en),
      .csr_wr_wid  (csr_wr_wid),
      .csr_wr_addr (csr_wr_addr),
      .csr_wr_data (csr_wr_data),
      .itr_valid   (itr_valid),
      .itr_wid     (itr_wid),
      .itr_cause   (itr_cause),
      .itr_ready   (itr_ready),
      .itr_busy    (itr_busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   logic [7:0] m_mie [WC];
   logic [7:0] m_mip [WC];
   int         m_last;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic rd_now(input int wid, input logic [3:0] off, output logic [31:0] d);
      csr_rd_en   = 1'b1;
      csr_rd_wid  = 2'(wid);
      csr_rd_addr = AB'(VX_HW_ITR_CTRL_BEGIN) + AB'(off);
      #1;
      d = csr_rd_data[31:0];
   endtask

   task automatic csr_rd(input int wid, input logic [3:0] off, output logic [31:0] d);
      @(negedge clk);
      rd_now(wid, off, d);
   endtask

   task automatic csr_wr(input int wid, input logic [3:0] off, input logic [31:0] d);
      @(negedge clk);
      csr_wr_en   = 1'b1;
      csr_wr_wid  = 2'(wid);
      csr_wr_addr = AB'(VX_HW_ITR_CTRL_BEGIN) + AB'(off);
      csr_wr_data = {TC{d}};
      @(negedge clk);
      csr_wr_en   = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      irq_in = '0;
      itr_ready = 1'b0;
      csr_wr_en = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int w = 0; w < WC; w++) begin
         m_mie[w] = '0;
         m_mip[w] = '0;
      end
      m_last = WC - 1;
   endtask

   task automatic pulse(input logic [NL-1:0] mask);
      @(negedge clk);
      irq_in = mask;
      repeat (3) @(negedge clk);
      irq_in = '0;
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_valid(input string tag, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         #1;
         if (itr_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk({tag, "_valid_timeout"}, 32'(itr_valid), 32'd1);
   endtask

   task automatic accept();
      itr_ready = 1'b1;
      @(negedge clk);
      itr_ready = 1'b0;
   endtask

   // Next grant from spec rules: first warp after the last served with an
   // enabled pending line, lowest such line.
   task automatic predict(output bit found, output int pw, output int pc);
      found = 1'b0;
      pw = 0;
      pc = 0;
      for (int i = 1; i <= WC && !found; i++) begin
         int w;
         w = (m_last + i) % WC;
         for (int k = 0; k < NL; k++) begin
            if (!found && m_mip[w][k] && m_mie[w][k]) begin
               found = 1'b1;
               pw = w;
               pc = k;
            end
         end
      end
   endtask

   initial begin
      logic [31:0] d;
      bit ok;

      // ---- 1: reset while a request is outstanding
      do_reset();
      chk("rst_valid", 32'(itr_valid), 0);
      chk("rst_busy", 32'(itr_busy), 0);
      csr_wr(0, HW_ITR_MIE, 32'h1);
      csr_wr(0, HW_ITR_GIE, 32'h1);
      pulse(8'h01);
      wait_valid("t1", ok);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("t1_valid_in_reset", 32'(itr_valid), 0);
      rd_now(0, HW_ITR_MIE, d);    chk("t1_mie0", d, 0);
      rd_now(0, HW_ITR_MIP, d);    chk("t1_mip0", d, 0);
      rd_now(0, HW_ITR_GIE, d);    chk("t1_gie", d, 0);
      @(negedge clk);
      reset = 1'b1;

      // ---- 2: single interrupt, accept, EOI
      do_reset();
      csr_wr(1, HW_ITR_MIE, 32'h04);
      csr_wr(0, HW_ITR_GIE, 32'h1);
      rd_now(1, HW_ITR_MIE, d);
      chk("t2_mie1", d, 32'h04);
      chk("t2_lanes", 32'(csr_rd_data == {TC{d}}), 1);
      pulse(8'h04);
      wait_valid("t2", ok);
      chk("t2_wid", 32'(itr_wid), 1);
      chk("t2_cause", 32'(itr_cause), 2);
      accept();
      rd_now(1, HW_ITR_MIP, d);    chk("t2_mip1", d, 0);
      rd_now(0, HW_ITR_MIP, d);    chk("t2_mip0", d, 32'h04);
      rd_now(1, HW_ITR_MCAUSE, d); chk("t2_mcause1", d, 32'h80000002);
      chk("t2_busy", 32'(itr_busy), 1);
      chk("t2_valid_after_acc", 32'(itr_valid), 0);
      csr_wr(1, HW_ITR_EOI, 32'h0);
      rd_now(1, HW_ITR_MCAUSE, d); chk("t2_mcause1_eoi", d, 0);
      chk("t2_busy_eoi", 32'(itr_busy), 0);

      // ---- 3: round-robin across all warps
      do_reset();
      for (int w = 0; w < WC; w++) csr_wr(w, HW_ITR_MIE, 32'h01);
      csr_wr(0, HW_ITR_GIE, 32'h1);
      pulse(8'h01);
      for (int w = 0; w < WC; w++) begin
         wait_valid("t3", ok);
         chk($sformatf("t3_wid%0d", w), 32'(itr_wid), 32'(w));
         chk($sformatf("t3_cause%0d", w), 32'(itr_cause), 0);
         accept();
         csr_wr(w, HW_ITR_EOI, 32'h0);
      end

      // ---- 4: stall with ready low, EOI from wrong warp
      do_reset();
      csr_wr(1, HW_ITR_MIE, 32'h10);
      csr_wr(0, HW_ITR_GIE, 32'h1);
      pulse(8'h10);
      wait_valid("t4", ok);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk("t4_hold_valid", 32'(itr_valid), 1);
         chk("t4_hold_wid", 32'(itr_wid), 1);
         chk("t4_hold_cause", 32'(itr_cause), 4);
      end
      accept();
      csr_wr(2, HW_ITR_EOI, 32'h0);
      #1;
      chk("t4_busy_wrong_eoi", 32'(itr_busy), 1);
      rd_now(1, HW_ITR_MCAUSE, d); chk("t4_mcause1", d, 32'h80000004);
      csr_wr(1, HW_ITR_EOI, 32'h0);
      #1;
      chk("t4_busy_eoi", 32'(itr_busy), 0);

      // ---- 5: edge set beats W1C in the same cycle; GIE=0 blocks requests
      do_reset();
      csr_wr(0, HW_ITR_MIE, 32'h08);
      @(negedge clk);
      irq_in = 8'h08;
      @(negedge clk);
      @(negedge clk);
      csr_wr_en   = 1'b1;
      csr_wr_wid  = 2'd0;
      csr_wr_addr = AB'(VX_HW_ITR_CTRL_BEGIN) + AB'(HW_ITR_MIP);
      csr_wr_data = {TC{32'h08}};
      @(negedge clk);
      csr_wr_en = 1'b0;
      irq_in = '0;
      rd_now(0, HW_ITR_MIP, d);    chk("t5_mip0_set_wins", d, 32'h08);
      csr_wr(0, HW_ITR_MIP, 32'h08);
      rd_now(0, HW_ITR_MIP, d);    chk("t5_mip0_w1c", d, 0);
      rd_now(2, HW_ITR_MIP, d);    chk("t5_mip2", d, 32'h08);
      repeat (8) @(negedge clk);
      #1;
      chk("t5_no_valid", 32'(itr_valid), 0);
      chk("t5_no_busy", 32'(itr_busy), 0);
      rd_now(0, 4'd12, d);         chk("t5_unmapped", d, 0);

`ifdef HW_ITR_TIMER_EN
      // ---- 6: timer compare raises line 0 once
      do_reset();
      csr_wr(0, HW_ITR_MTIMECMP_HI, 32'h0);
      csr_wr(0, HW_ITR_MTIMECMP_LO, 32'd100);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         csr_rd(0, HW_ITR_MIP, d);
         if (d[0]) ok = 1'b1;
      end
      chk("t6_timer_fired", 32'(ok), 1);
      rd_now(0, HW_ITR_MTIME_LO, d);
      chk("t6_mtime_window", 32'(d >= 32'd100 && d <= 32'd106), 1);
      csr_wr(0, HW_ITR_MIP, 32'h01);
      repeat (30) @(negedge clk);
      rd_now(0, HW_ITR_MIP, d);    chk("t6_once_only", d, 0);
`else
      rd_now(0, HW_ITR_MTIME_LO, d);    chk("t6_no_mtime", d, 0);
      rd_now(0, HW_ITR_MTIMECMP_LO, d); chk("t6_no_mtimecmp", d, 0);
`endif

      // ---- randomized rounds against the reference model
      do_reset();
      for (int r = 0; r < 16; r++) begin
         logic [7:0] mask;
         bit found;
         int pw, pc, dly, other;
         csr_wr(0, HW_ITR_GIE, 32'h0);
         for (int w = 0; w < WC; w++) begin
            m_mie[w] = 8'($urandom);
            csr_wr(w, HW_ITR_MIE, 32'(m_mie[w]));
         end
         mask = 8'($urandom_range(1, 255));
         pulse(mask);
         for (int w = 0; w < WC; w++) m_mip[w] |= mask;
         if ($urandom_range(0, 1) == 1) begin
            int cw;
            logic [7:0] cm;
            cw = $urandom_range(0, WC - 1);
            cm = 8'($urandom);
            csr_wr(cw, HW_ITR_MIP, 32'(cm));
            m_mip[cw] &= ~cm;
         end
         csr_wr(0, HW_ITR_GIE, 32'h1);
         for (int g = 0; g < 40; g++) begin
            predict(found, pw, pc);
            if (!found) break;
            wait_valid("rnd", ok);
            if (!ok) break;
            chk("rnd_wid", 32'(itr_wid), 32'(pw));
            chk("rnd_cause", 32'(itr_cause), 32'(pc));
            dly = $urandom_range(0, 3);
            for (int i = 0; i < dly; i++) begin
               @(negedge clk);
               #1;
               chk("rnd_hold", {itr_valid, 1'b0, itr_wid, 1'b0, itr_cause},
                   {1'b1, 1'b0, 2'(pw), 1'b0, 3'(pc)});
            end
            accept();
            m_mip[pw][pc] = 1'b0;
            m_last = pw;
            rd_now(pw, HW_ITR_MCAUSE, d);
            chk("rnd_mcause", d, 32'h80000000 | 32'(pc));
            other = (pw + 1 + $urandom_range(0, WC - 2)) % WC;
            csr_wr(other, HW_ITR_EOI, 32'h0);
            #1;
            chk("rnd_busy_wrong_eoi", 32'(itr_busy), 1);
            csr_wr(pw, HW_ITR_EOI, 32'h0);
            rd_now(pw, HW_ITR_MCAUSE, d);
            chk("rnd_mcause_eoi", d, 0);
         end
         repeat (3) @(negedge clk);
         #1;
         chk("rnd_idle_valid", 32'(itr_valid), 0);
         for (int w = 0; w < WC; w++) begin
            rd_now(w, HW_ITR_MIP, d);
            chk($sformatf("rnd_mip%0d", w), d, 32'(m_mip[w]));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
